// File: rtl/multpool_core.sv
// Bit-serial multiplier downstream of the multpool config/trigger register.
// Optional macro MULTPOOL_MODRED_EN switches the datapath to interleaved modular multiplication.
module multpool_core #(
  parameter int unsigned NBITS = 128
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 trigmult,
  input  logic                 rd_en_out,
  input  logic [3*NBITS-1:0]   wr_reg,
  output logic [2*NBITS-1:0]   multpool_result,
  output logic                 busy,
  output logic                 done,
  output logic                 result_valid,
  output logic                 trig_dropped,
  output logic                 mod_err
);

  localparam int unsigned CW = $clog2(NBITS);
`ifdef MULTPOOL_MODRED_EN
  localparam int unsigned AW = NBITS + 2;
`else
  localparam int unsigned AW = 2 * NBITS;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [NBITS-1:0]  a_reg, b_reg;
  logic [AW-1:0]     acc, acc_next;
  logic [CW-1:0]     cnt;
  logic              last_bit;
  logic              trig_accept;

  assign last_bit    = (cnt == CW'(NBITS - 1));
  assign trig_accept = (state == IDLE) && trigmult;

`ifdef MULTPOOL_MODRED_EN
  logic [NBITS-1:0]  m_reg;
  logic [NBITS+2:0]  t0, t1, t2, m_ext;

  // acc < M and A < M keep t below 3M, so two conditional subtractions reduce fully.
  always_comb begin
    m_ext    = {3'b000, m_reg};
    t0       = {1'b0, acc, 1'b0} + (b_reg[NBITS-1] ? {3'b000, a_reg} : '0);
    t1       = (t0 >= m_ext) ? t0 - m_ext : t0;
    t2       = (t1 >= m_ext) ? t1 - m_ext : t1;
    acc_next = t2[AW-1:0];
  end
`else
  logic unused_m;
  assign unused_m = ^wr_reg[3*NBITS-1:2*NBITS];

  always_comb begin
    acc_next = (acc << 1) + (b_reg[NBITS-1] ? {{NBITS{1'b0}}, a_reg} : '0);
  end
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigmult) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      a_reg           <= '0;
      b_reg           <= '0;
      acc             <= '0;
      cnt             <= '0;
      multpool_result <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
`ifdef MULTPOOL_MODRED_EN
      m_reg           <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigmult) begin
            a_reg <= wr_reg[NBITS-1:0];
            b_reg <= wr_reg[2*NBITS-1:NBITS];
`ifdef MULTPOOL_MODRED_EN
            m_reg <= wr_reg[3*NBITS-1:2*NBITS];
`endif
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc   <= acc_next;
          b_reg <= b_reg << 1;
          cnt   <= cnt + 1'b1;
        end
        DONE: begin
`ifdef MULTPOOL_MODRED_EN
          multpool_result <= (m_reg == '0) ? '0 : {{NBITS{1'b0}}, acc[NBITS-1:0]};
`else
          multpool_result <= acc;
`endif
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Sticky flags: a set on the same edge as a read strobe takes priority.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      result_valid <= 1'b0;
      trig_dropped <= 1'b0;
    end else begin
      if (state == DONE)   result_valid <= 1'b1;
      else if (rd_en_out)  result_valid <= 1'b0;

      if (trigmult && !trig_accept) trig_dropped <= 1'b1;
      else if (rd_en_out)           trig_dropped <= 1'b0;
    end
  end

`ifdef MULTPOOL_MODRED_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      mod_err <= 1'b0;
    end else begin
      if (state == DONE && m_reg == '0) mod_err <= 1'b1;
      else if (rd_en_out)               mod_err <= 1'b0;
    end
  end
`else
  assign mod_err = 1'b0;
`endif

endmodule

// File: tb/tb_multpool_core.sv
// Directed self-checking bench for multpool_core with NBITS=8.
module tb_multpool_core;

  localparam int unsigned NBITS = 8;

  logic                 hclk;
  logic                 hresetn;
  logic                 trigmult;
  logic                 rd_en_out;
  logic [3*NBITS-1:0]   wr_reg;
  logic [2*NBITS-1:0]   multpool_result;
  logic                 busy;
  logic                 done;
  logic                 result_valid;
  logic                 trig_dropped;
  logic                 mod_err;

  int checks = 0;
  int errors = 0;

  multpool_core #(.NBITS(NBITS)) dut (
    .hclk            (hclk),
    .hresetn         (hresetn),
    .trigmult        (trigmult),
    .rd_en_out       (rd_en_out),
    .wr_reg          (wr_reg),
    .multpool_result (multpool_result),
    .busy            (busy),
    .done            (done),
    .result_valid    (result_valid),
    .trig_dropped    (trig_dropped),
    .mod_err         (mod_err)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  // Drives a one-cycle trigger; returns just after the trigger edge E.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    wr_reg   = {m, b, a};
    trigmult = 1'b1;
    tick();
    trigmult = 1'b0;
  endtask

  task automatic read_pulse();
    rd_en_out = 1'b1;
    tick();
    rd_en_out = 1'b0;
  endtask

  task automatic test_reset();
    hresetn   = 1'b0;
    trigmult  = 1'b0;
    rd_en_out = 1'b0;
    wr_reg    = '0;
    tick();
    tick();
    checks++;
    if ({multpool_result, busy, done, result_valid, trig_dropped, mod_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h busy=%b done=%b rv=%b td=%b me=%b, want all 0",
               multpool_result, busy, done, result_valid, trig_dropped, mod_err);
    end
    hresetn = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    start_op(8'h0F, 8'h11, 8'h00);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_at_E: got %b, want 1", busy);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_run_E+%0d: got busy=%b done=%b, want 1 0", i, busy, done);
      end
    end
    tick();
    checks++;
    if (done !== 1'b1 || multpool_result !== 16'h00FF || result_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: got done=%b res=%h rv=%b busy=%b, want 1 00ff 1 0",
               done, multpool_result, result_valid, busy);
    end
    checks++;
    if (mod_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_mod_err: got %b, want 0", mod_err);
    end
    tick();
    checks++;
    if (done !== 1'b0 || multpool_result !== 16'h00FF) begin
      errors++;
      $display("FAIL basic_after_done: got done=%b res=%h, want 0 00ff", done, multpool_result);
    end
    read_pulse();
  endtask

  task automatic test_back_to_back();
    int gap;
    start_op(8'hFF, 8'hFF, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    tick();
    checks++;
    if (done !== 1'b1 || multpool_result !== 16'hFE01) begin
      errors++;
      $display("FAIL b2b_first: got done=%b res=%h, want 1 fe01", done, multpool_result);
    end
    start_op(8'h02, 8'h03, 8'h00);
    gap = 1;
    while (done !== 1'b1 && gap < 20) begin
      tick();
      gap++;
    end
    checks++;
    if (gap != 10) begin
      errors++;
      $display("FAIL b2b_gap: got %0d cycles, want 10", gap);
    end
    checks++;
    if (multpool_result !== 16'h0006) begin
      errors++;
      $display("FAIL b2b_second: got res=%h, want 0006", multpool_result);
    end
    read_pulse();
  endtask

  task automatic test_trig_dropped();
    int extra_done;
    start_op(8'h12, 8'h34, 8'h00);
    for (int i = 0; i < 3; i++) tick();
    wr_reg   = {8'h00, 8'h77, 8'h55};
    trigmult = 1'b1;
    tick();
    trigmult = 1'b0;
    checks++;
    if (trig_dropped !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_flag: got td=%b busy=%b, want 1 1", trig_dropped, busy);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL drop_early_done: got %b, want 0", done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || multpool_result !== 16'h03A8) begin
      errors++;
      $display("FAIL drop_result: got done=%b res=%h, want 1 03a8", done, multpool_result);
    end
    extra_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) extra_done++;
    end
    checks++;
    if (extra_done != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_single_done: got extra=%0d busy=%b, want 0 0", extra_done, busy);
    end
    read_pulse();
    checks++;
    if (trig_dropped !== 1'b0 || result_valid !== 1'b0 || multpool_result !== 16'h03A8) begin
      errors++;
      $display("FAIL drop_read_clear: got td=%b rv=%b res=%h, want 0 0 03a8",
               trig_dropped, result_valid, multpool_result);
    end
  endtask

  task automatic test_rd_collision();
    start_op(8'h07, 8'h09, 8'h00);
    tick();
    trigmult  = 1'b1;
    rd_en_out = 1'b1;
    tick();
    trigmult  = 1'b0;
    rd_en_out = 1'b0;
    checks++;
    if (trig_dropped !== 1'b1) begin
      errors++;
      $display("FAIL rd_vs_drop_set: got td=%b, want 1", trig_dropped);
    end
    for (int i = 0; i < 6; i++) tick();
    rd_en_out = 1'b1;
    tick();
    rd_en_out = 1'b0;
    checks++;
    if (done !== 1'b1 || result_valid !== 1'b1 || trig_dropped !== 1'b0 || multpool_result !== 16'h003F) begin
      errors++;
      $display("FAIL rd_on_done: got done=%b rv=%b td=%b res=%h, want 1 1 0 003f",
               done, result_valid, trig_dropped, multpool_result);
    end
    read_pulse();
    checks++;
    if (result_valid !== 1'b0 || multpool_result !== 16'h003F) begin
      errors++;
      $display("FAIL rd_after_done: got rv=%b res=%h, want 0 003f", result_valid, multpool_result);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    start_op(8'h0F, 8'h11, 8'h00);
    for (int i = 0; i < 4; i++) tick();
    hresetn = 1'b0;
    #1;
    checks++;
    if ({multpool_result, busy, done, result_valid, trig_dropped, mod_err} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got res=%h busy=%b done=%b rv=%b td=%b, want all 0",
               multpool_result, busy, done, result_valid, trig_dropped);
    end
    tick();
    hresetn = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL reset_mid_no_done: got %0d active cycles, want 0", seen_done);
    end
    start_op(8'h03, 8'h05, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    tick();
    checks++;
    if (done !== 1'b1 || multpool_result !== 16'h000F) begin
      errors++;
      $display("FAIL reset_mid_fresh: got done=%b res=%h, want 1 000f", done, multpool_result);
    end
    read_pulse();
  endtask

  task automatic test_zero_operand();
    start_op(8'h00, 8'h5A, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_latency: got done=%b busy=%b at E+8, want 0 1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || multpool_result !== 16'h0000) begin
      errors++;
      $display("FAIL zero_result: got done=%b res=%h, want 1 0000", done, multpool_result);
    end
    read_pulse();
  endtask

  task automatic test_modred();
    start_op(8'h0A, 8'h0C, 8'h0D);
    for (int i = 0; i < 8; i++) tick();
    tick();
    checks++;
    if (done !== 1'b1 || multpool_result !== 16'h0003 || mod_err !== 1'b0) begin
      errors++;
      $display("FAIL modred_result: got done=%b res=%h me=%b, want 1 0003 0", done, multpool_result, mod_err);
    end
    start_op(8'h05, 8'h07, 8'h00);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL modred_zero_latency: got done=%b at E+8, want 0", done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || multpool_result !== 16'h0000 || mod_err !== 1'b1) begin
      errors++;
      $display("FAIL modred_m_zero: got done=%b res=%h me=%b, want 1 0000 1", done, multpool_result, mod_err);
    end
    read_pulse();
    checks++;
    if (mod_err !== 1'b0) begin
      errors++;
      $display("FAIL modred_err_clear: got %b, want 0", mod_err);
    end
  endtask

  initial begin
    test_reset();
`ifdef MULTPOOL_MODRED_EN
    test_modred();
`else
    test_basic();
    test_back_to_back();
    test_trig_dropped();
    test_rd_collision();
    test_reset_mid();
    test_zero_operand();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
